// File: rtl/ls299.sv
// SN74LS299 8-bit universal shift/storage register: async clear, hold,
// shift right (SR enters QA), shift left (SL enters QH), parallel load.
module ls299 (
  input  logic       _CLK,
  input  logic       _CLR,
  input  logic       _S0,
  input  logic       _S1,
  input  logic       _G1,
  input  logic       _G2,
  input  logic       _SR,
  input  logic       _SL,
  input  logic [7:0] _D_IN,
  output logic [7:0] _Q_OUT,
  output logic       _Q_OE,
  output logic       _QA_S,
  output logic       _QH_S
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  mode_e      mode;
  logic [7:0] q;

  assign mode = mode_e'({_S1, _S0});

  always_ff @(posedge _CLK or negedge _CLR) begin
    if (!_CLR) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_SHR:  q <= {q[6:0], _SR};
        MODE_SHL:  q <= {_SL, q[7:1]};
        MODE_LOAD: q <= _D_IN;
        default:   q <= q;
      endcase
    end
  end

  // Pins are released during load so the bus can drive the register inputs.
  assign _Q_OE  = ~_G1 & ~_G2 & ~(_S0 & _S1);
  assign _Q_OUT = q;
  assign _QA_S  = q[0];
  assign _QH_S  = q[7];

endmodule
